// File: rtl/draw_pkg.sv
// Shared definitions for the frame draw scheduler.
// Contents:
//   state_t       scheduler state encoding
//   CLEAR_COLOR   background colour written during the screen clear
//   PLAYER_COLOR  colour of the player marker
//   OBJ_*         field layout of one packed object record in obj_coords
//   obj_color()   per-object sprite colour lookup
package draw_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCAN,
    SPRITE,
    PLAYER,
    DONE
  } state_t;

  localparam logic [15:0] CLEAR_COLOR  = 16'h000F;
  localparam logic [15:0] PLAYER_COLOR = 16'hFFFF;

  // One object record: {valid, y[7:0], x[8:0]}
  localparam int unsigned OBJ_W     = 18;
  localparam int unsigned X_LSB     = 0;
  localparam int unsigned Y_LSB     = 9;
  localparam int unsigned VALID_BIT = 17;

  localparam int unsigned NUM_COLORS = 10;

  // Colour table repeats if more objects than entries are configured.
  function automatic logic [15:0] obj_color(input int unsigned idx);
    case (idx % NUM_COLORS)
      0:       return 16'h00FF;
      1:       return 16'h0F0F;
      2:       return 16'hF00F;
      3:       return 16'h0FFF;
      4:       return 16'hF0FF;
      5:       return 16'hFF0F;
      6:       return 16'h735F;
      7:       return 16'h892F;
      8:       return 16'h937F;
      default: return 16'h283F;
    endcase
  endfunction

endpackage

// File: rtl/raster_counter.sv
// Two-dimensional raster counter, cx fastest.
// Ports:
//   CLOCK_50  clock
//   reset     synchronous active-high reset (counters to 0)
//   clear     force both counters to 0 on the next edge
//   step      advance one position; wraps to (0,0) after (W_MAX-1, H_MAX-1)
//   cx, cy    current position
//   last      high while at (W_MAX-1, H_MAX-1)
module raster_counter #(
  parameter int unsigned W_MAX = 320,
  parameter int unsigned H_MAX = 240,
  localparam int unsigned XW = (W_MAX > 1) ? $clog2(W_MAX) : 1,
  localparam int unsigned YW = (H_MAX > 1) ? $clog2(H_MAX) : 1
) (
  input  logic          CLOCK_50,
  input  logic          reset,
  input  logic          clear,
  input  logic          step,
  output logic [XW-1:0] cx,
  output logic [YW-1:0] cy,
  output logic          last
);

  localparam logic [XW-1:0] X_END = XW'(W_MAX - 1);
  localparam logic [YW-1:0] Y_END = YW'(H_MAX - 1);

  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;

  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (clear) begin
      cx_d = '0;
      cy_d = '0;
    end else if (step) begin
      if (cx_q == X_END) begin
        cx_d = '0;
        cy_d = (cy_q == Y_END) ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx   = cx_q;
  assign cy   = cy_q;
  assign last = (cx_q == X_END) && (cy_q == Y_END);

endmodule

// File: rtl/frame_draw_scheduler.sv
// Sequences one video frame into the VGA adapter pixel-write port:
// full-screen clear, then each valid 16x16 ball sprite, then the player marker.
// Ports:
//   CLOCK_50     50 MHz clock
//   reset        synchronous active-high reset
//   frame_start  one-cycle frame request (collapses into one pending request while busy)
//   obj_coords   NUM_OBJ packed {valid, y, x} records
//   centerX/Y    player marker top-left corner
//   x, y, color  pixel address and colour (Moore, decoded from registers)
//   writeEn      pixel write strobe; low for clipped sprite pixels
//   busy         high while a frame is in progress
//   frame_done   one-cycle pulse at the end of each frame
module frame_draw_scheduler
  import draw_pkg::*;
#(
  parameter int unsigned NUM_OBJ     = 10,
  parameter int unsigned SCREEN_W    = 320,
  parameter int unsigned SCREEN_H    = 240,
  parameter int unsigned SPRITE_SIZE = 16
) (
  input  logic                     CLOCK_50,
  input  logic                     reset,
  input  logic                     frame_start,
  input  logic [NUM_OBJ*OBJ_W-1:0] obj_coords,
  input  logic [8:0]               centerX,
  input  logic [7:0]               centerY,
  output logic [8:0]               x,
  output logic [7:0]               y,
  output logic [15:0]              color,
  output logic                     writeEn,
  output logic                     busy,
  output logic                     frame_done
);

  localparam int unsigned IDX_W  = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int unsigned CLR_XW = (SCREEN_W > 1) ? $clog2(SCREEN_W) : 1;
  localparam int unsigned CLR_YW = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
  localparam int unsigned SPR_W  = (SPRITE_SIZE > 1) ? $clog2(SPRITE_SIZE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     pending_q, pending_d;
  logic                     snap_en;
  logic [NUM_OBJ*OBJ_W-1:0] snap_obj_q;
  logic [8:0]               snap_cx_q;
  logic [7:0]               snap_cy_q;

  logic [CLR_XW-1:0] clr_cx;
  logic [CLR_YW-1:0] clr_cy;
  logic              clr_last;
  logic [SPR_W-1:0]  spr_cx;
  logic [SPR_W-1:0]  spr_cy;
  logic              spr_last;

  // Unpack the snapshot into per-object fields.
  logic [8:0] obj_x     [NUM_OBJ];
  logic [7:0] obj_y     [NUM_OBJ];
  logic       obj_valid [NUM_OBJ];

  for (genvar g = 0; g < NUM_OBJ; g++) begin : g_unpack
    assign obj_x[g]     = snap_obj_q[g*OBJ_W + X_LSB +: 9];
    assign obj_y[g]     = snap_obj_q[g*OBJ_W + Y_LSB +: 8];
    assign obj_valid[g] = snap_obj_q[g*OBJ_W + VALID_BIT];
  end

  raster_counter #(
    .W_MAX (SCREEN_W),
    .H_MAX (SCREEN_H)
  ) u_clear_raster (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clear    (state_q == IDLE),
    .step     (state_q == CLEAR),
    .cx       (clr_cx),
    .cy       (clr_cy),
    .last     (clr_last)
  );

  // Shared by SPRITE and PLAYER; it wraps to (0,0) after each sprite, and SCAN
  // clears it before every new sprite.
  raster_counter #(
    .W_MAX (SPRITE_SIZE),
    .H_MAX (SPRITE_SIZE)
  ) u_sprite_raster (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .clear    (state_q == SCAN),
    .step     ((state_q == SPRITE) || (state_q == PLAYER)),
    .cx       (spr_cx),
    .cy       (spr_cy),
    .last     (spr_last)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pending_d = pending_q;
    snap_en   = 1'b0;

    if (frame_start && (state_q != IDLE)) begin
      pending_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (frame_start || pending_q) begin
          snap_en   = 1'b1;
          pending_d = 1'b0;
          idx_d     = '0;
          state_d   = CLEAR;
        end
      end
      CLEAR: begin
        if (clr_last) begin
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (obj_valid[idx_q]) begin
          state_d = SPRITE;
        end else if (idx_q == LAST_IDX) begin
          state_d = PLAYER;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      SPRITE: begin
        if (spr_last) begin
          if (idx_q == LAST_IDX) begin
            state_d = PLAYER;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SCAN;
          end
        end
      end
      PLAYER: begin
        if (spr_last) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      pending_q  <= 1'b0;
      snap_obj_q <= '0;
      snap_cx_q  <= '0;
      snap_cy_q  <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      if (snap_en) begin
        snap_obj_q <= obj_coords;
        snap_cx_q  <= centerX;
        snap_cy_q  <= centerY;
      end
    end
  end

  // Sprite pixel address, widened so off-screen sums are detected, not wrapped.
  logic [8:0] base_x;
  logic [7:0] base_y;
  logic [9:0] sum_x;
  logic [8:0] sum_y;
  logic       on_screen;

  always_comb begin
    base_x    = (state_q == PLAYER) ? snap_cx_q : obj_x[idx_q];
    base_y    = (state_q == PLAYER) ? snap_cy_q : obj_y[idx_q];
    sum_x     = {1'b0, base_x} + 10'(spr_cx);
    sum_y     = {1'b0, base_y} + 9'(spr_cy);
    on_screen = (sum_x < 10'(SCREEN_W)) && (sum_y < 9'(SCREEN_H));
  end

  always_comb begin
    x          = '0;
    y          = '0;
    color      = CLEAR_COLOR;
    writeEn    = 1'b0;
    frame_done = 1'b0;
    busy       = (state_q != IDLE);
    unique case (state_q)
      CLEAR: begin
        x       = 9'(clr_cx);
        y       = 8'(clr_cy);
        writeEn = 1'b1;
      end
      SPRITE: begin
        x       = sum_x[8:0];
        y       = sum_y[7:0];
        color   = obj_color(32'(idx_q));
        writeEn = on_screen;
      end
      PLAYER: begin
        x       = sum_x[8:0];
        y       = sum_y[7:0];
        color   = PLAYER_COLOR;
        writeEn = on_screen;
      end
      DONE: begin
        frame_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Self-checking bench for frame_draw_scheduler on a reduced 40x30 screen so
// that several complete frames fit in a short run. Every observed pixel write
// is compared against a list built from the drawing rules, and frame lengths
// against the closed-form cycle count.
module tb_frame_draw_scheduler;

  localparam int unsigned NO = 10;
  localparam int unsigned TW = 40;
  localparam int unsigned TH = 30;
  localparam int unsigned SS = 16;
  localparam int unsigned CW = NO * 18;
  localparam int LIMIT = TW*TH + NO + SS*SS*(NO+1) + 20;

  typedef struct packed {
    logic [8:0]  px;
    logic [7:0]  py;
    logic [15:0] pc;
  } wr_t;

  logic          CLOCK_50 = 1'b0;
  logic          reset = 1'b1;
  logic          frame_start = 1'b0;
  logic [CW-1:0] obj_coords = '0;
  logic [8:0]    centerX = '0;
  logic [7:0]    centerY = '0;
  logic [8:0]    x;
  logic [7:0]    y;
  logic [15:0]   color;
  logic          writeEn;
  logic          busy;
  logic          frame_done;

  int  n_checks = 0;
  int  n_errors = 0;
  int  cyc = 0;
  int  done_cnt = 0;
  wr_t got_q[$];
  wr_t exp_q[$];
  logic [15:0] pal [10] = '{16'h00FF, 16'h0F0F, 16'hF00F, 16'h0FFF, 16'hF0FF,
                            16'hFF0F, 16'h735F, 16'h892F, 16'h937F, 16'h283F};

  frame_draw_scheduler #(
    .NUM_OBJ     (NO),
    .SCREEN_W    (TW),
    .SCREEN_H    (TH),
    .SPRITE_SIZE (SS)
  ) dut (
    .CLOCK_50    (CLOCK_50),
    .reset       (reset),
    .frame_start (frame_start),
    .obj_coords  (obj_coords),
    .centerX     (centerX),
    .centerY     (centerY),
    .x           (x),
    .y           (y),
    .color       (color),
    .writeEn     (writeEn),
    .busy        (busy),
    .frame_done  (frame_done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    if (writeEn === 1'b1) got_q.push_back({x, y, color});
    if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  function automatic logic [CW-1:0] set_obj(input logic [CW-1:0] oc, input int i, input int ox,
                                            input int oy, input bit v);
    logic [CW-1:0] m;
    logic [CW-1:0] f;
    m = {{(CW-18){1'b0}}, 18'h3FFFF} << (i*18);
    f = {{(CW-18){1'b0}}, v, 8'(oy), 9'(ox)} << (i*18);
    return (oc & ~m) | f;
  endfunction

  task automatic add_sprite(input int ox, input int oy, input logic [15:0] c);
    for (int dy = 0; dy < int'(SS); dy++)
      for (int dx = 0; dx < int'(SS); dx++)
        if (ox + dx < int'(TW) && oy + dy < int'(TH))
          exp_q.push_back({9'(ox + dx), 8'(oy + dy), c});
  endtask

  // Appends one frame's expected writes to exp_q; len = cycles from start sample to frame_done.
  task automatic model_frame(input logic [CW-1:0] oc, input int cx, input int cy, output int len);
    int k;
    logic [CW-1:0] s;
    k = 0;
    for (int py = 0; py < int'(TH); py++)
      for (int px = 0; px < int'(TW); px++)
        exp_q.push_back({9'(px), 8'(py), 16'h000F});
    for (int i = 0; i < int'(NO); i++) begin
      s = oc >> (i*18);
      if (s[17]) begin
        k++;
        add_sprite(int'(s[8:0]), int'(s[16:9]), pal[i % 10]);
      end
    end
    add_sprite(cx, cy, 16'hFFFF);
    len = int'(TW*TH + NO) + int'(SS*SS) * (k + 1) + 1;
  endtask

  function automatic int first_mismatch();
    int n;
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic pulse_start(output int s);
    @(posedge CLOCK_50);
    #1 frame_start = 1'b1;
    s = cyc;
    @(posedge CLOCK_50);
    #1 frame_start = 1'b0;
  endtask

  task automatic wait_done(output int dc, output bit ok);
    ok = 1'b0;
    dc = -1;
    for (int i = 0; i < LIMIT; i++) begin
      @(negedge CLOCK_50);
      if (frame_done === 1'b1) begin
        dc = cyc;
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    int s, s2, dc, len, base, nw, mm;
    bit found, ok;
    reset = 1'b1;
    repeat (3) @(posedge CLOCK_50);
    #1 reset = 1'b0;
    @(negedge CLOCK_50);
    n_checks++;
    if (writeEn !== 1'b0) begin n_errors++; $display("FAIL reset_we: got %b want 0", writeEn); end
    n_checks++;
    if ({x, y} !== 17'd0) begin n_errors++; $display("FAIL reset_xy: got %0d,%0d want 0,0", x, y); end
    n_checks++;
    if (color !== 16'h000F) begin n_errors++; $display("FAIL reset_color: got %h want 000F", color); end
    n_checks++;
    if ({busy, frame_done} !== 2'b00) begin
      n_errors++; $display("FAIL reset_busy_done: got %b want 00", {busy, frame_done});
    end

    // Abort mid-clear with a second request pending; neither may survive reset.
    obj_coords = set_obj('0, 0, 3, 3, 1'b1);
    pulse_start(s);
    pulse_start(s2);
    found = 1'b0;
    for (int i = 0; i < int'(TW*TH); i++) begin
      @(negedge CLOCK_50);
      if (writeEn === 1'b1 && x == 9'd17 && y == 8'd3) begin found = 1'b1; break; end
    end
    n_checks++;
    if (!found) begin n_errors++; $display("FAIL reset_reach_pixel: got 0 want 1"); end
    reset = 1'b1;
    @(posedge CLOCK_50);
    #1 reset = 1'b0;
    @(negedge CLOCK_50);
    n_checks++;
    if ({writeEn, busy, frame_done} !== 3'b000) begin
      n_errors++; $display("FAIL midreset_outputs: got %b want 000", {writeEn, busy, frame_done});
    end
    base = done_cnt;
    #1 nw = got_q.size();
    repeat (40) @(negedge CLOCK_50);
    #1;
    n_checks++;
    if (got_q.size() != nw || done_cnt != base || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL midreset_quiet: got writes=%0d done=%0d busy=%b want 0 0 0",
               got_q.size() - nw, done_cnt - base, busy);
    end

    // Fresh frame restarts from (0,0).
    got_q.delete();
    exp_q.delete();
    obj_coords = '0;
    centerX = 9'd2;
    centerY = 8'd3;
    model_frame(obj_coords, 2, 3, len);
    pulse_start(s);
    @(negedge CLOCK_50);
    n_checks++;
    if (writeEn !== 1'b1 || x !== 9'd0 || y !== 8'd0) begin
      n_errors++; $display("FAIL restart_first: got we=%b x=%0d y=%0d want 1 0 0", writeEn, x, y);
    end
    wait_done(dc, ok);
    #1;
    n_checks++;
    if (!ok || dc - s != len) begin
      n_errors++; $display("FAIL restart_len: got %0d want %0d", dc - s, len);
    end
    mm = first_mismatch();
    n_checks++;
    if (got_q.size() != exp_q.size() || mm != -1) begin
      n_errors++; $display("FAIL restart_stream: got n=%0d first_bad=%0d want n=%0d first_bad=-1",
                           got_q.size(), mm, exp_q.size());
    end
  endtask

  task automatic test_no_objects();
    int s, dc, len, mm;
    bit ok;
    got_q.delete();
    exp_q.delete();
    obj_coords = '0;
    centerX = 9'd10;
    centerY = 8'd5;
    model_frame(obj_coords, 10, 5, len);
    pulse_start(s);
    @(negedge CLOCK_50);
    n_checks++;
    if (busy !== 1'b1) begin n_errors++; $display("FAIL noobj_busy: got %b want 1", busy); end
    wait_done(dc, ok);
    n_checks++;
    if (!ok || dc - s != int'(TW*TH + NO + SS*SS + 1)) begin
      n_errors++; $display("FAIL noobj_len: got %0d want %0d", dc - s, TW*TH + NO + SS*SS + 1);
    end
    @(negedge CLOCK_50);
    #1;
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL noobj_idle: got busy=%b want 0", busy); end
    mm = first_mismatch();
    n_checks++;
    if (got_q.size() != int'(TW*TH + SS*SS) || mm != -1) begin
      n_errors++; $display("FAIL noobj_stream: got n=%0d first_bad=%0d want n=%0d first_bad=-1",
                           got_q.size(), mm, TW*TH + SS*SS);
    end
  endtask

  task automatic test_single_object();
    int s, dc, len, mm;
    bit ok;
    got_q.delete();
    exp_q.delete();
    obj_coords = set_obj('0, 0, 20, 10, 1'b1);
    centerX = 9'd0;
    centerY = 8'd0;
    model_frame(obj_coords, 0, 0, len);
    pulse_start(s);
    wait_done(dc, ok);
    #1;
    n_checks++;
    if (!ok || dc - s != int'(TW*TH + NO + 2*SS*SS + 1)) begin
      n_errors++; $display("FAIL single_len: got %0d want %0d", dc - s, TW*TH + NO + 2*SS*SS + 1);
    end
    mm = first_mismatch();
    n_checks++;
    if (got_q.size() != exp_q.size() || mm != -1) begin
      n_errors++; $display("FAIL single_stream: got n=%0d first_bad=%0d want n=%0d first_bad=-1",
                           got_q.size(), mm, exp_q.size());
    end
  endtask

  task automatic test_corner_clip();
    int s, dc, len, mm, n_obj;
    bit ok;
    got_q.delete();
    exp_q.delete();
    obj_coords = set_obj('0, 3, TW - 10, TH - 10, 1'b1);
    centerX = 9'd1;
    centerY = 8'd1;
    model_frame(obj_coords, 1, 1, len);
    pulse_start(s);
    wait_done(dc, ok);
    #1;
    n_obj = 0;
    foreach (got_q[i]) if (got_q[i].pc == 16'h0FFF) n_obj++;
    n_checks++;
    if (n_obj != 100) begin n_errors++; $display("FAIL corner_count: got %0d want 100", n_obj); end
    n_checks++;
    if (!ok || dc - s != len) begin n_errors++; $display("FAIL corner_len: got %0d want %0d", dc - s, len); end
    mm = first_mismatch();
    n_checks++;
    if (got_q.size() != exp_q.size() || mm != -1) begin
      n_errors++; $display("FAIL corner_stream: got n=%0d first_bad=%0d want n=%0d first_bad=-1",
                           got_q.size(), mm, exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int s, s2, d1, d2, len1, len2, mm, base;
    bit ok1, ok2;
    logic [CW-1:0] oc1, oc2;
    got_q.delete();
    exp_q.delete();
    oc1 = set_obj('0, 2, 5, 5, 1'b1);
    oc2 = set_obj(set_obj(oc1, 2, 5, 5, 1'b0), 5, 12, 8, 1'b1);
    model_frame(oc1, 1, 1, len1);
    model_frame(oc2, 20, 20, len2);
    base = done_cnt;
    obj_coords = oc1;
    centerX = 9'd1;
    centerY = 8'd1;
    pulse_start(s);
    repeat (100) @(posedge CLOCK_50);
    #1;
    obj_coords = oc2;
    centerX = 9'd20;
    centerY = 8'd20;
    pulse_start(s2);
    repeat (50) @(posedge CLOCK_50);
    pulse_start(s2);
    wait_done(d1, ok1);
    n_checks++;
    if (!ok1 || d1 - s != len1) begin n_errors++; $display("FAIL b2b_len1: got %0d want %0d", d1 - s, len1); end
    @(negedge CLOCK_50);
    n_checks++;
    if (busy !== 1'b0) begin n_errors++; $display("FAIL b2b_gap_idle: got busy=%b want 0", busy); end
    @(negedge CLOCK_50);
    n_checks++;
    if (busy !== 1'b1 || writeEn !== 1'b1 || x !== 9'd0 || y !== 8'd0) begin
      n_errors++;
      $display("FAIL b2b_restart: got busy=%b we=%b x=%0d y=%0d want 1 1 0 0", busy, writeEn, x, y);
    end
    wait_done(d2, ok2);
    n_checks++;
    if (!ok2 || d2 - (d1 + 1) != len2) begin
      n_errors++; $display("FAIL b2b_len2: got %0d want %0d", d2 - (d1 + 1), len2);
    end
    repeat (50) @(negedge CLOCK_50);
    #1;
    n_checks++;
    if (done_cnt - base != 2 || busy !== 1'b0) begin
      n_errors++; $display("FAIL b2b_frames: got %0d busy=%b want 2 0", done_cnt - base, busy);
    end
    mm = first_mismatch();
    n_checks++;
    if (got_q.size() != exp_q.size() || mm != -1) begin
      n_errors++; $display("FAIL b2b_stream: got n=%0d first_bad=%0d want n=%0d first_bad=-1",
                           got_q.size(), mm, exp_q.size());
    end
  endtask

  task automatic test_random();
    int s, dc, len, mm, cx, cy;
    bit ok;
    logic [CW-1:0] oc;
    for (int r = 0; r < 3; r++) begin
      got_q.delete();
      exp_q.delete();
      oc = '0;
      for (int i = 0; i < int'(NO); i++)
        oc = set_obj(oc, i, int'($urandom_range(0, TW + 8)), int'($urandom_range(0, TH + 8)),
                     $urandom_range(0, 2) == 0);
      cx = int'($urandom_range(0, TW));
      cy = int'($urandom_range(0, TH));
      obj_coords = oc;
      centerX = 9'(cx);
      centerY = 8'(cy);
      model_frame(oc, cx, cy, len);
      pulse_start(s);
      obj_coords = ~oc;
      wait_done(dc, ok);
      #1;
      n_checks++;
      if (!ok || dc - s != len) begin
        n_errors++; $display("FAIL rand%0d_len: got %0d want %0d", r, dc - s, len);
      end
      mm = first_mismatch();
      n_checks++;
      if (got_q.size() != exp_q.size() || mm != -1) begin
        n_errors++; $display("FAIL rand%0d_stream: got n=%0d first_bad=%0d want n=%0d first_bad=-1",
                             r, got_q.size(), mm, exp_q.size());
      end
      repeat (3) @(negedge CLOCK_50);
    end
  endtask

  initial begin
    test_reset();
    test_no_objects();
    test_single_object();
    test_corner_clip();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
